// File: rtl/pulse_pkg.sv
// pulse_pkg
// Shared definitions for the pulse stretcher slice.
//   - ST_IDLE / ST_HOLD / ST_GAP : FSM state encoding (2'b11 is unused and
//                                  recovers to ST_IDLE)
//   - term_count(n)              : terminal counter value, 2^(n-1)-1, for an
//                                  n-bit timer, so that hold and gap phases
//                                  each last 2^(n-1) clk cycles
// No ports (package). Optional feature macro used by the slice:
// PULSE_STRETCH_RETRIGGER_EN.

package pulse_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_HOLD = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;

  // Last counter value of a phase; a phase spans counts 0..term_count(n).
  function automatic int term_count(input int n);
    return (1 << (n - 1)) - 1;
  endfunction

endpackage

// File: rtl/pulse_timer.sv
// pulse_timer
// N-bit phase counter with synchronous clear and count enable. The counter
// saturates at the terminal value so it can never wrap, even if the enable
// were held past the end of a phase.
// Ports:
//   clk      in  system clock, posedge
//   n_reset  in  synchronous active-low reset (counter to 0)
//   clear    in  force the counter to 0 on the next edge (wins over enable)
//   enable   in  advance the counter by one on the next edge
//   terminal out high while the counter holds term_count(N)

module pulse_timer
  import pulse_pkg::*;
#(
  parameter int N = 11
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [N-1:0] TERM = N'(term_count(N));

  logic [N-1:0] cnt;

  // Clear has priority so the FSM can restart a phase on any state change.
  always_ff @(posedge clk) begin
    if (!n_reset || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != TERM)) begin
      cnt <= cnt + N'(1);
    end
  end

  assign terminal = (cnt == TERM);

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher
// Turns single-cycle event requests into human-visible pulses: each accepted
// event drives out_drv to ACTIVE_LVL for 2^(N-1) cycles, followed by a gap of
// 2^(N-1) cycles at the inactive level. One further event can be queued
// (pending) while a pulse or gap is in progress; a second one is dropped and
// flagged on overflow.
// Ports:
//   clk       in  system clock, posedge
//   n_reset   in  synchronous active-low reset
//   event_in  in  single-cycle event request
//   out_drv   out stretched pulse, registered
//   busy      out registered (state != IDLE) | pending
//   overflow  out registered one-cycle flag for a dropped event
// Optional feature: define PULSE_STRETCH_RETRIGGER_EN to let an event during
// the hold phase restart the hold counter instead of queueing.

module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int   N          = 11,
  parameter logic ACTIVE_LVL = 1'b1
) (
  input  logic clk,
  input  logic n_reset,
  input  logic event_in,
  output logic out_drv,
  output logic busy,
  output logic overflow
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       pending;
  logic       pending_nxt;
  logic       drop;
  logic       cnt_clear;
  logic       cnt_en;
  logic       cnt_term;

  pulse_timer #(
    .N(N)
  ) u_timer (
    .clk      (clk),
    .n_reset  (n_reset),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .terminal (cnt_term)
  );

  // Next-state, pending-flag and counter-control decisions. The counter is
  // cleared on every state change so each phase starts from zero.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    drop        = 1'b0;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (event_in) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_term) begin
          state_nxt = ST_GAP;
          cnt_clear = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
`ifdef PULSE_STRETCH_RETRIGGER_EN
        // Retrigger extends the hold; this also overrides the transition to
        // GAP when the event lands on the final hold cycle.
        if (event_in) begin
          state_nxt = ST_HOLD;
          cnt_clear = 1'b1;
          cnt_en    = 1'b0;
        end
`else
        if (event_in) begin
          if (pending) begin
            drop = 1'b1;
          end else begin
            pending_nxt = 1'b1;
          end
        end
`endif
      end
      ST_GAP: begin
        if (cnt_term) begin
          cnt_clear = 1'b1;
          if (pending || event_in) begin
            // One request starts the new hold; if both a queued and a fresh
            // event exist, the fresh one becomes the new queued request.
            state_nxt   = ST_HOLD;
            pending_nxt = pending & event_in;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          cnt_en = 1'b1;
          if (event_in) begin
            if (pending) begin
              drop = 1'b1;
            end else begin
              pending_nxt = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        pending_nxt = 1'b0;
        cnt_clear   = 1'b1;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state itself (one cycle event-to-pulse latency).
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= ST_IDLE;
      pending  <= 1'b0;
      out_drv  <= ~ACTIVE_LVL;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      out_drv  <= (state_nxt == ST_HOLD) ? ACTIVE_LVL : ~ACTIVE_LVL;
      busy     <= (state_nxt != ST_IDLE) | pending_nxt;
      overflow <= drop;
    end
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter N, default 11, counter width; hold and gap length are each 2^(N-1) clk cycles.
REQ-002 Parameter ACTIVE_LVL, default 1'b1, level driven on out_drv while stretching.
REQ-003 clk  input  1  system clock; all state updates on posedge clk.
REQ-004 n_reset  input  1  reset, synchronous, active-low.
REQ-005 event_in  input  1  single-cycle event request from the processor (synchronous to clk, no debounce).
REQ-006 out_drv  output  1  stretched, human-visible pulse (LED/pin), registered.
REQ-007 busy  output  1  high while the state is not IDLE or pending is set, registered.
REQ-008 overflow  output  1  one-cycle pulse when an event is dropped, registered.

Function
REQ-009 States IDLE, HOLD, GAP; one N-bit counter cnt; one 1-bit pending flag.
REQ-010 IDLE: out_drv = ~ACTIVE_LVL; event_in=1 at edge k -> HOLD, cnt=0, out_drv=ACTIVE_LVL from edge k (visible cycle k+1); latency exactly 1 cycle.
REQ-011 HOLD: out_drv=ACTIVE_LVL; cnt increments each cycle; when cnt reaches 2^(N-1)-1 -> GAP, cnt=0; out_drv active exactly 2^(N-1) cycles.
REQ-012 GAP: out_drv=~ACTIVE_LVL; cnt increments; at cnt = 2^(N-1)-1 exit: pending or event_in -> HOLD, cnt=0; else -> IDLE.
REQ-013 Event during HOLD/GAP (excluding the GAP exit cycle) with pending=0 sets pending=1.
REQ-014 Event with pending=1 (and not consumed that cycle) is dropped; overflow=1 for that cycle only.
REQ-015 GAP exit cycle with pending=1 and event_in=1: pending consumed to start HOLD, pending stays 1 (new event queued), no overflow.
REQ-016 GAP exit with pending=1, event_in=0: pending cleared, HOLD starts.
REQ-017 Counter never wraps: compared against terminal value, reset to 0 on every state change.
REQ-018 busy = (state != IDLE) | pending, registered, same cycle as the state update.

Reset
REQ-019 n_reset=0 at a posedge: state=IDLE, cnt=0, pending=0, out_drv=~ACTIVE_LVL, busy=0, overflow=0.
REQ-020 Reset mid-HOLD or mid-GAP aborts immediately; pending event discarded without overflow.
REQ-021 event_in ignored in any cycle where n_reset=0.

Configuration
REQ-022 Macro PULSE_STRETCH_RETRIGGER_EN defined: event_in during HOLD restarts cnt=0 (hold extended), pending untouched, no overflow; GAP behaviour unchanged.
REQ-023 Macro undefined: event during HOLD handled by REQ-013/REQ-014; no retrigger logic synthesized.

Structure
REQ-024 Shared package pulse_pkg holds the state encoding (IDLE=2'b00, HOLD=2'b01, GAP=2'b10) and terminal-count function of N.
REQ-025 Sub-module pulse_timer (N-bit counter with clear, enable, terminal flag) is natural; FSM and pending flag stay in pulse_stretcher.
REQ-026 Encoding 2'b11 is unreachable; it SHALL recover to IDLE on the next cycle.

Verification (N=4, hold=gap=8 cycles, ACTIVE_LVL=1)
REQ-027 Single event at cycle 10 -> out_drv high cycles 11-18, low 19-26, busy low from cycle 27, overflow never.
REQ-028 Events at cycles 10 and 13 -> second pulse high cycles 27-34; busy continuous 11-42.
REQ-029 Events at 10, 13, 15 -> overflow high cycle 16 only; exactly two pulses produced.
REQ-030 Pending set, new event on GAP exit cycle -> three back-to-back pulses separated by 8-cycle gaps, no overflow.
REQ-031 n_reset low at cycle 14 during HOLD with pending -> cycle 15 all outputs at reset values; no later pulse.
REQ-032 With PULSE_STRETCH_RETRIGGER_EN, events at 10 and 14 -> out_drv high cycles 11-22, single pulse, pending stays 0.
